// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter slice.
// Imported by the interface, the scoreboard and the arbiter top.
package rf_write_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int REG_COUNT  = 1 << REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     data_t;

   localparam reg_addr_t REG_ZERO = '0;

   // Which requester owns the write port in the current cycle.
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WB   = 2'd1,
      GNT_MD   = 2'd2
   } grant_e;

   // One-hot register mask; r0 maps to an empty mask because it is never written or tracked.
   function automatic logic [REG_COUNT-1:0] reg_onehot(input reg_addr_t rd);
      reg_onehot = '0;
      if (rd != REG_ZERO) reg_onehot[rd] = 1'b1;
   endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of WB, MDU, decode and RegisterFile-write signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface rf_write_arbiter_if;
   import rf_write_arbiter_pkg::*;

   logic      wb_valid;
   reg_addr_t wb_rd;
   data_t     wb_data;
   logic      wb_ready;

   logic      md_valid;
   reg_addr_t md_rd;
   data_t     md_data;
   logic      md_ready;

   logic      iss_valid;
   reg_addr_t iss_rd;

   reg_addr_t dec_rs;
   reg_addr_t dec_rt;
   reg_addr_t dec_rd;
   logic      dec_stall;

   logic      rf_we;
   reg_addr_t rf_waddr;
   data_t     rf_wdata;

   modport slave (
      input  wb_valid, wb_rd, wb_data,
      output wb_ready,
      input  md_valid, md_rd, md_data,
      output md_ready,
      input  iss_valid, iss_rd,
      input  dec_rs, dec_rt, dec_rd,
      output dec_stall,
      output rf_we, rf_waddr, rf_wdata
   );

   modport master (
      output wb_valid, wb_rd, wb_data,
      input  wb_ready,
      output md_valid, md_rd, md_data,
      input  md_ready,
      output iss_valid, iss_rd,
      output dec_rs, dec_rt, dec_rd,
      input  dec_stall,
      input  rf_we, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/rf_write_arbiter_scoreboard.sv
// Busy scoreboard of registers with an MDU write outstanding; three lookup ports.
// A commit in the current cycle already hides its register from lookups.
module rf_scoreboard
   import rf_write_arbiter_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      set_en_i,
   input  reg_addr_t set_rd_i,
   input  logic      clr_en_i,
   input  reg_addr_t clr_rd_i,
   input  reg_addr_t look_a_i,
   input  reg_addr_t look_b_i,
   input  reg_addr_t look_c_i,
   output logic      busy_a_o,
   output logic      busy_b_o,
   output logic      busy_c_o
);

   logic [REG_COUNT-1:0] busy_q, busy_d;
   logic [REG_COUNT-1:0] set_mask, clr_mask, busy_look;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      set_mask  = set_en_i ? reg_onehot(set_rd_i) : '0;
      clr_mask  = clr_en_i ? reg_onehot(clr_rd_i) : '0;
      busy_look = busy_q & ~clr_mask;
      busy_d    = busy_look | set_mask;  // a new issue to the committing rd stays pending
   end

   assign busy_a_o = busy_look[look_a_i];
   assign busy_b_o = busy_look[look_b_i];
   assign busy_c_o = busy_look[look_c_i];

   // NOTE: sequential state uses non-blocking assignments; the busy vector is cleared by
   // reset because the MDU is reset with it and its pending results are discarded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   // Decode stalls on dec_rd, so an issue may only target a register that is free this cycle.
   a_no_reissue_while_busy: assert property (@(posedge clk) disable iff (reset)
      (set_en_i && set_rd_i != REG_ZERO) |-> !busy_look[set_rd_i]);

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RegisterFile write port between WB and the MDU with starvation forcing,
// and stalls decode on hazards against MDU writes still in flight.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input logic               clk,
   input logic               reset,
   rf_write_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             force_md;
   grant_e           grant;
   logic             rf_we_q, rf_we_d;
   reg_addr_t        rf_waddr_q, rf_waddr_d;
   data_t            rf_wdata_q, rf_wdata_d;
   logic             hit_rs, hit_rt, hit_rd;

   always_comb begin
      force_md = bus.md_valid && (starve_cnt_q == LIMIT_C);

      // WB normally wins; a starved MDU takes the port for exactly one cycle.
      grant = GNT_NONE;
      if (bus.md_valid && (!bus.wb_valid || force_md)) grant = GNT_MD;
      else if (bus.wb_valid)                           grant = GNT_WB;

      starve_cnt_d = '0;
      if (bus.md_valid && grant != GNT_MD)
         starve_cnt_d = (starve_cnt_q == LIMIT_C) ? starve_cnt_q : starve_cnt_q + CNT_W'(1);

      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      case (grant)
         GNT_WB: if (bus.wb_rd != REG_ZERO) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.wb_rd;
            rf_wdata_d = bus.wb_data;
         end
         GNT_MD: if (bus.md_rd != REG_ZERO) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.md_rd;
            rf_wdata_d = bus.md_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt_q <= '0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= REG_ZERO;
         rf_wdata_q   <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
      end
   end

   rf_scoreboard u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .set_en_i (bus.iss_valid),
      .set_rd_i (bus.iss_rd),
      .clr_en_i (grant == GNT_MD),
      .clr_rd_i (bus.md_rd),
      .look_a_i (bus.dec_rs),
      .look_b_i (bus.dec_rt),
      .look_c_i (bus.dec_rd),
      .busy_a_o (hit_rs),
      .busy_b_o (hit_rt),
      .busy_c_o (hit_rd)
   );

   assign bus.wb_ready  = !force_md;
   assign bus.md_ready  = (grant == GNT_MD);
   assign bus.dec_stall = hit_rs | hit_rt | hit_rd;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;

endmodule
